// File: rtl/mem_stage_ctrl.sv
// Purpose: MEM-stage sequencer that issues one dcache request per load/store and extracts load results.
// Latency: best case two stall cycles (request accepted in IDLE, response on the next cycle).
// Backpressure: request held stable while dc_req_ready is low; mem_stall holds the pipeline until the response.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_is_load,
  input  logic        mem_is_store,
  input  logic        mem_unsigned,
  input  logic [1:0]  mem_size,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic        mem_wr_en,
  output logic        mem_stall,
  output logic [63:0] load_data,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic        dc_req_we,
  output logic [63:0] dc_req_addr,
  output logic [63:0] dc_req_wdata,
  output logic [1:0]  dc_req_size,
  input  logic        dc_resp_valid,
  input  logic [63:0] dc_resp_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  lane_q, lane_d;
  logic [63:0] load_data_q, load_data_d;

  logic        memop;
  logic        req_vld;
  logic        stall;
  logic        capture;
  logic        req_fire;
  logic [63:0] resp_shifted;
  logic [63:0] resp_ext;

  assign memop    = mem_valid & (mem_is_load | mem_is_store);
  assign req_fire = req_vld & dc_req_ready;

  // Request attributes are straight from the MEM register, which cannot change until mem_wr_en.
  assign dc_req_we    = mem_is_store;
  assign dc_req_addr  = mem_addr;
  assign dc_req_wdata = mem_wdata;
  assign dc_req_size  = mem_size;

  // Handshake outputs are forced quiet for as long as reset is held, not just after the first edge.
  assign dc_req_valid = req_vld & reset_n;
  assign mem_stall    = stall & reset_n;
  assign load_data    = load_data_q;

  // Next-state and handshake/stall decode; a flush (mem_wr_en while busy) either withdraws or drains.
  always_comb begin
    state_d = state_q;
    req_vld = 1'b0;
    stall   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (memop) begin
          req_vld = 1'b1;
          stall   = 1'b1;
          if (dc_req_ready) begin
            state_d = mem_wr_en ? S_DRAIN : S_WAIT;
          end else if (!mem_wr_en) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        req_vld = 1'b1;
        stall   = 1'b1;
        if (dc_req_ready) begin
          state_d = mem_wr_en ? S_DRAIN : S_WAIT;
        end else if (mem_wr_en) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dc_resp_valid) begin
          // A response landing on the flush edge is already consumed, so there is nothing left to drain.
          if (mem_wr_en) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            capture = is_load_q;
          end
        end else if (mem_wr_en) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (mem_wr_en) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        stall = memop;
        if (dc_resp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Remember how to extend the result of the request that was just accepted.
  always_comb begin
    is_load_d  = is_load_q;
    unsigned_d = unsigned_q;
    size_d     = size_q;
    lane_d     = lane_q;
    if (req_fire) begin
      is_load_d  = mem_is_load;
      unsigned_d = mem_unsigned;
      size_d     = mem_size;
      lane_d     = mem_addr[2:0];
    end
  end

  // Pick the addressed lane out of the returned dword and sign/zero extend it.
  always_comb begin
    resp_shifted = dc_resp_data >> {lane_q, 3'b000};
    resp_ext     = dc_resp_data;
    unique case (size_q)
      2'd0: resp_ext = unsigned_q ? {56'd0, resp_shifted[7:0]}
                                  : {{56{resp_shifted[7]}}, resp_shifted[7:0]};
      2'd1: resp_ext = unsigned_q ? {48'd0, resp_shifted[15:0]}
                                  : {{48{resp_shifted[15]}}, resp_shifted[15:0]};
      2'd2: resp_ext = unsigned_q ? {32'd0, resp_shifted[31:0]}
                                  : {{32{resp_shifted[31]}}, resp_shifted[31:0]};
      default: resp_ext = dc_resp_data;
    endcase
    load_data_d = capture ? resp_ext : load_data_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      is_load_q   <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= 2'd0;
      lane_q      <= 3'd0;
      load_data_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      unsigned_q  <= unsigned_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised bench for mem_stage_ctrl: drives a MEM register, traffic control and a dcache model,
// and checks handshake/stall/load results against an expectation derived from the request rules.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        mem_valid = 1'b0, mem_is_load = 1'b0, mem_is_store = 1'b0, mem_unsigned = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [63:0] mem_addr = 64'd0, mem_wdata = 64'd0;
  logic        mem_wr_en = 1'b0;
  logic        mem_stall;
  logic [63:0] load_data;
  logic        dc_req_valid;
  logic        dc_req_ready = 1'b0;
  logic        dc_req_we;
  logic [63:0] dc_req_addr, dc_req_wdata;
  logic [1:0]  dc_req_size;
  logic        dc_resp_valid = 1'b0;
  logic [63:0] dc_resp_data = 64'd0;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .mem_unsigned(mem_unsigned), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_stall(mem_stall),
    .load_data(load_data), .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata),
    .dc_req_size(dc_req_size), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data)
  );

  typedef struct {
    bit          vld;
    bit          ld;
    bit          st;
    bit          uns;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
  } instr_t;

  typedef struct {
    int          id;
    logic [63:0] val;
  } exp_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference state: current MEM instruction and what the dcache has seen of it.
  instr_t      cur;
  int          cur_id = 0;
  bit          cur_acc = 0;
  int          cur_acc_cyc = 0;
  bit          cur_done = 0;
  int          cur_done_cyc = 0;
  bit          outst = 0;
  bit          outst_at_start = 0;
  int          resp_cyc = 0;
  int          req_id = 0;
  instr_t      req_ins;
  logic [63:0] req_data = 64'd0;
  logic [63:0] last_ld = 64'd0;
  exp_t        sb[$];
  instr_t      script[$];
  bit          load_new = 0;
  int          rst_hold = 0;
  int          checked_id = -1;
  bit          mon_en = 0;

  // Stimulus knobs.
  int          ready_pct = 70;
  int          lat_max = 3;
  int          flush_pct = 5;
  int          retire_pct = 70;
  bit          force_en = 0;
  logic [63:0] force_val = 64'd0;

  function automatic bit is_memop(input instr_t i);
    return i.vld && (i.ld || i.st);
  endfunction

  // Value a load of 'sz' at 'addr' must return given the dword the cache delivered.
  function automatic logic [63:0] ext(input logic [63:0] d, input logic [63:0] addr,
                                      input logic [1:0] sz, input bit uns);
    int          nbits;
    logic [63:0] v;
    logic [63:0] mask;
    nbits = 8 << sz;
    v = d >> (8 * addr[2:0]);
    if (nbits == 64) return v;
    mask = (64'd1 << nbits) - 64'd1;
    v = v & mask;
    if (!uns && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic instr_t mk(input bit ld, input bit uns, input logic [1:0] sz,
                                input logic [63:0] a, input logic [63:0] wd);
    instr_t i;
    i.vld = 1; i.ld = ld; i.st = !ld; i.uns = uns; i.size = sz; i.addr = a; i.wdata = wd;
    return i;
  endfunction

  function automatic instr_t gen_instr();
    instr_t i;
    int     k;
    k = $urandom_range(0, 9);
    i.vld = (k != 0);
    i.ld = 0;
    i.st = 0;
    if (k == 0) i.ld = 1'($urandom_range(0, 1));
    else if (k >= 2 && k <= 5) i.ld = 1;
    else if (k >= 6) i.st = 1;
    i.uns = 1'($urandom_range(0, 1));
    i.size = 2'($urandom_range(0, 3));
    i.addr = {$urandom, $urandom};
    i.addr = i.addr & ~((64'd1 << i.size) - 64'd1);
    i.wdata = {$urandom, $urandom};
    return i;
  endfunction

  task automatic drive_mem(input instr_t i);
    mem_valid = i.vld; mem_is_load = i.ld; mem_is_store = i.st; mem_unsigned = i.uns;
    mem_size = i.size; mem_addr = i.addr; mem_wdata = i.wdata;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
  endtask

  // One clock of stimulus: MEM register, dcache response/ready, traffic control, then bookkeeping.
  task automatic cycle();
    bit   wr;
    bit   hs;
    bit   rsp;
    bit   done_now;
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (load_new) begin
      cur = (script.size() > 0) ? script.pop_front() : gen_instr();
      drive_mem(cur);
      cur_id++;
      cur_acc = 0;
      cur_done = 0;
      load_new = 0;
    end
    if (rst_hold > 0) begin
      reset_n = 1'b0;
      rst_hold--;
      outst = 0; outst_at_start = 0; cur_acc = 0; cur_done = 0; last_ld = 64'd0;
      sb.delete();
      mem_wr_en = 1'b0; dc_resp_valid = 1'b0; dc_req_ready = 1'b0;
      return;
    end
    reset_n = 1'b1;
    outst_at_start = outst;
    rsp = outst && (resp_cyc == cyc);
    dc_resp_valid = rsp;
    dc_resp_data = rsp ? req_data : {$urandom, $urandom};
    dc_req_ready = ($urandom_range(0, 99) < ready_pct);
    #1;
    done_now = cur_done && (cur_done_cyc < cyc);
    if (!is_memop(cur) || done_now) wr = ($urandom_range(0, 99) < retire_pct);
    else wr = ($urandom_range(0, 99) < flush_pct);
    mem_wr_en = wr;
    #1;
    hs = dc_req_valid && dc_req_ready && !outst_at_start;
    if (rsp) begin
      outst = 0;
      if (req_id == cur_id && !wr) begin
        cur_done = 1;
        cur_done_cyc = cyc;
        if (req_ins.ld) last_ld = ext(req_data, req_ins.addr, req_ins.size, req_ins.uns);
        e.id = cur_id;
        e.val = last_ld;
        sb.push_back(e);
      end
    end
    if (hs) begin
      outst = 1;
      resp_cyc = cyc + int'($urandom_range(1, lat_max));
      req_id = cur_id;
      req_ins = cur;
      req_data = force_en ? force_val : {$urandom, $urandom};
      cur_acc = 1;
      cur_acc_cyc = cyc;
    end
    if (wr) load_new = 1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Monitor: compares DUT outputs mid-cycle and pops the scoreboard when the DUT reports completion.
  always @(negedge clk) begin : monitor
    bit   m;
    bit   es;
    bit   ev;
    bit   found;
    exp_t e;
    if (mon_en) begin
      if (!reset_n) begin
        chk("rst_req_valid", 64'(dc_req_valid), 64'd0);
        chk("rst_stall", 64'(mem_stall), 64'd0);
        chk("rst_load_data", load_data, 64'd0);
      end else begin
        m  = is_memop(cur);
        es = m && !(cur_done && cur_done_cyc < cyc);
        ev = m && !(cur_acc && cur_acc_cyc < cyc) && !outst_at_start;
        chk("mem_stall", 64'(mem_stall), 64'(es));
        chk("dc_req_valid", 64'(dc_req_valid), 64'(ev));
        if (dc_req_valid) begin
          chk("req_we", 64'(dc_req_we), 64'(cur.st));
          chk("req_addr", dc_req_addr, cur.addr);
          chk("req_wdata", dc_req_wdata, cur.wdata);
          chk("req_size", 64'(dc_req_size), 64'(cur.size));
        end
        if (m && !mem_stall && checked_id != cur_id) begin
          checked_id = cur_id;
          while (sb.size() > 0 && sb[0].id != cur_id) void'(sb.pop_front());
          found = (sb.size() > 0);
          chk("completion_expected", 64'(found), 64'd1);
          if (found) begin
            e = sb.pop_front();
            chk("load_data", load_data, e.val);
          end
        end
      end
    end
  end

  initial begin
    cur = mk(1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
    cur.vld = 0;
    cur.st = 0;
    req_ins = cur;
    drive_mem(cur);
    #1;
    reset_n = 1'b0;
    mon_en = 1;
    rst_hold = 3;
    run(4);

    // Signed/unsigned byte load of a known dword, then back-to-back loads at minimum latency.
    ready_pct = 100; lat_max = 1; flush_pct = 0; retire_pct = 100;
    force_en = 1; force_val = 64'h0000_0000_8000_0000;
    script.push_back(mk(1'b1, 1'b0, 2'd0, 64'h1003, 64'd0));
    script.push_back(mk(1'b1, 1'b1, 2'd0, 64'h1003, 64'd0));
    script.push_back(mk(1'b1, 1'b0, 2'd1, 64'h1002, 64'd0));
    script.push_back(mk(1'b1, 1'b0, 2'd2, 64'h1000, 64'd0));
    script.push_back(mk(1'b0, 1'b0, 2'd3, 64'h2000, 64'hDEAD_BEEF_0123_4567));
    script.push_back(mk(1'b1, 1'b1, 2'd3, 64'h1008, 64'd0));
    run(30);

    // Store under heavy ready backpressure, then a mix with slow responses.
    force_en = 0;
    ready_pct = 20; lat_max = 3; retire_pct = 80;
    script.push_back(mk(1'b0, 1'b0, 2'd3, 64'h2008, 64'h1122_3344_5566_7788));
    run(200);

    // Flush-heavy traffic: withdrawals, drains and responses racing with new instructions.
    ready_pct = 50; lat_max = 4; flush_pct = 20; retire_pct = 60;
    run(1500);

    // Reset while a response is outstanding.
    ready_pct = 80; lat_max = 4; flush_pct = 5;
    for (int r = 0; r < 6; r++) begin
      run(100);
      for (int w = 0; w < 50 && !outst; w++) cycle();
      rst_hold = 2;
      run(3);
    end

    // General random traffic.
    ready_pct = 70; lat_max = 3; flush_pct = 5; retire_pct = 70;
    run(2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
